// File: rtl/uP_pkg.sv
// Shared definitions for the processor's RAM side: bus widths and the
// RAM bus arbiter state encodings.
package uP_pkg;

    // Default RAM geometry: 4-bit x 4K data RAM.
    localparam int UP_ADDR_W = 12;
    localparam int UP_DATA_W = 4;

    // Width of the external-port starvation counter.
    localparam int UP_WAIT_W = 4;

    // RAM bus arbiter states.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_EXT  = 2'b01,
        ARB_DONE = 2'b10
    } arb_state_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating wait counter for the external port. Counts cycles during which
// the external requester was refused because the core held the RAM.
// Clear has priority over increment; the count never passes i_limit.
module arb_wait_counter
    import uP_pkg::*;
#(
    parameter int W = UP_WAIT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    input  logic         i_clr,
    input  logic [W-1:0] i_limit,
    output logic [W-1:0] o_cnt,
    output logic         o_sat
);

    logic [W-1:0] r_cnt;
    logic         w_sat;

    assign w_sat = (r_cnt == i_limit);

    // Count refused cycles, clear on request drop or grant, hold at limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_sat = w_sat;

endmodule

// File: rtl/ram_bus_arbiter.sv
// Arbitrates the data RAM between the processor core and an external
// debug/loader port. The core has priority; the external port gets idle
// slots, or after STARVE_LIMIT refused cycles it steals one cycle by
// stalling the core. A DONE cycle after every external access guarantees
// the core at least one slot between external accesses.
//
// External handshake: the requester raises ext_req with ext_we/ext_addr/
// ext_wdata and holds them stable until ext_ack (a one-cycle pulse). It
// drops ext_req in the ack cycle for a single transfer; if ext_req is still
// high in the following IDLE cycle, that is a new request. ext_rdata is
// valid in the ack cycle of a read and holds until the next external read.
module ram_bus_arbiter
    import uP_pkg::*;
#(
    parameter int ADDR_W       = UP_ADDR_W,
    parameter int DATA_W       = UP_DATA_W,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    // Core side
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    // External requester side
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_ack,
    output logic [DATA_W-1:0] ext_rdata,
    // RAM side
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    // Debug visibility
    output logic [1:0]        o_dbg_state,
    output logic [UP_WAIT_W-1:0] o_dbg_wait_cnt
);

    localparam logic [UP_WAIT_W-1:0] LIMIT = UP_WAIT_W'(STARVE_LIMIT);

    arb_state_t          r_state;
    logic                r_ext_we;
    logic [ADDR_W-1:0]   r_ext_addr;
    logic [DATA_W-1:0]   r_ext_wdata;
    logic                r_ext_ack;
    logic [DATA_W-1:0]   r_ext_rdata;

    logic                w_idle;
    logic                w_in_ext;
    logic                w_sat;
    logic                w_grant;
    logic                w_wait_inc;
    logic                w_wait_clr;
    logic [UP_WAIT_W-1:0] w_wait_cnt;

    assign w_idle   = (r_state == ARB_IDLE);
    assign w_in_ext = (r_state == ARB_EXT);

    // The core wins a simultaneous request unless the requester has
    // already waited STARVE_LIMIT cycles.
    assign w_grant    = w_idle && ext_req && (!cpu_cs || w_sat);
    assign w_wait_inc = w_idle && ext_req && !w_grant;
    assign w_wait_clr = !ext_req || w_grant;

    arb_wait_counter #(
        .W (UP_WAIT_W)
    ) u_wait_counter (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_wait_inc),
        .i_clr   (w_wait_clr),
        .i_limit (LIMIT),
        .o_cnt   (w_wait_cnt),
        .o_sat   (w_sat)
    );

    // Arbiter FSM with request latch, registered ack and ext read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_ext_we    <= 1'b0;
            r_ext_addr  <= '0;
            r_ext_wdata <= '0;
            r_ext_ack   <= 1'b0;
            r_ext_rdata <= '0;
        end else begin
            r_ext_ack <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant) begin
                        r_ext_we    <= ext_we;
                        r_ext_addr  <= ext_addr;
                        r_ext_wdata <= ext_wdata;
                        r_state     <= ARB_EXT;
                    end
                end
                ARB_EXT: begin
                    if (!r_ext_we) begin
                        r_ext_rdata <= ram_rdata;
                    end
                    r_ext_ack <= 1'b1;
                    r_state   <= ARB_DONE;
                end
                ARB_DONE: begin
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    // RAM mux: the core drives the RAM except during the external access cycle.
    always_comb begin
        ram_cs    = cpu_cs;
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        if (w_in_ext) begin
            ram_cs    = 1'b1;
            ram_we    = r_ext_we;
            ram_addr  = r_ext_addr;
            ram_wdata = r_ext_wdata;
        end
    end

    // A core access that collides with the external cycle is replayed next cycle.
    assign cpu_stall = w_in_ext && cpu_cs;
    assign cpu_rdata = ram_rdata;

    assign ext_ack   = r_ext_ack;
    assign ext_rdata = r_ext_rdata;

    assign o_dbg_state    = r_state;
    assign o_dbg_wait_cnt = w_wait_cnt;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: behavioural 4-bit x 4K RAM on the RAM side,
// directed scenarios for reset, idle access, starvation and back-to-back
// transfers, plus a short random write/read-back round.
module tb_ram_bus_arbiter;
    import uP_pkg::*;

    localparam int AW = 12;
    localparam int DW = 4;
    localparam int SL = 3;

    logic          clk;
    logic          reset;
    logic          cpu_cs;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_ack;
    logic [DW-1:0] ext_rdata;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [1:0]    dbg_state;
    logic [3:0]    dbg_wait_cnt;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q[$];

    logic [DW-1:0] mem [0:4095];

    ram_bus_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_cs         (cpu_cs),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rdata      (cpu_rdata),
        .cpu_stall      (cpu_stall),
        .ext_req        (ext_req),
        .ext_we         (ext_we),
        .ext_addr       (ext_addr),
        .ext_wdata      (ext_wdata),
        .ext_ack        (ext_ack),
        .ext_rdata      (ext_rdata),
        .ram_cs         (ram_cs),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .o_dbg_state    (dbg_state),
        .o_dbg_wait_cnt (dbg_wait_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: synchronous write, asynchronous read
    assign ram_rdata = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        next_cycle();
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        next_cycle();
        cpu_cs = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic cpu_read_check(input string tag, input logic [AW-1:0] a);
        next_cycle();
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        @(negedge clk);
        check(tag, 32'(cpu_rdata), 32'(exp_q.pop_front()));
        cpu_cs = 1'b0;
    endtask

    // One external transfer; returns in the ack cycle with ext_req dropped.
    task automatic ext_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got;
        got = 1'b0;
        next_cycle();
        ext_req = 1'b1; ext_we = we; ext_addr = a; ext_wdata = d;
        for (int k = 0; k < 20; k++) begin
            next_cycle();
            if (ext_ack) begin
                got = 1'b1;
                break;
            end
        end
        ext_req = 1'b0;
        check("ext_ack_seen", 32'(got), 32'd1);
        if (got && !we) check("ext_rdata", 32'(ext_rdata), 32'(exp_q.pop_front()));
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] stalled_d;
        logic [AW-1:0] ra;
        logic [AW-1:0] bb_addr [3];
        logic [DW-1:0] bb_data [3];
        int idx;

        reset = 1'b1;
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h055; cpu_wdata = '0;
        ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
        check("rst_wait", 32'(dbg_wait_cnt), 32'd0);
        check("rst_ack", 32'(ext_ack), 32'd0);
        check("rst_rdata", 32'(ext_rdata), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        check("rst_ram_cs", 32'(ram_cs), 32'd1);
        check("rst_ram_addr", 32'(ram_addr), 32'h055);
        next_cycle();
        reset = 1'b0;
        cpu_cs = 1'b0;

        // Reset in the middle of an external write
        next_cycle();
        ext_req = 1'b1; ext_we = 1'b1; ext_addr = 12'h0A0; ext_wdata = 4'h7;
        next_cycle();
        @(negedge clk);
        check("mid_state_ext", 32'(dbg_state), 32'(ARB_EXT));
        reset = 1'b1;
        #1;
        check("mid_rst_state", 32'(dbg_state), 32'(ARB_IDLE));
        check("mid_rst_ack", 32'(ext_ack), 32'd0);
        check("mid_rst_stall", 32'(cpu_stall), 32'd0);
        check("mid_rst_ram_cs", 32'(ram_cs), 32'd0);
        ext_req = 1'b0;
        next_cycle();
        reset = 1'b0;
        cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h0A0;
        @(negedge clk);
        check("mid_core_cs", 32'(ram_cs), 32'd1);
        check("mid_core_addr", 32'(ram_addr), 32'h0A0);
        check("mid_ack_low0", 32'(ext_ack), 32'd0);
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            cpu_cs = 1'b0;
            check("mid_ack_low", 32'(ext_ack), 32'd0);
        end

        // Idle external read with exact latency
        cpu_write(12'h123, 4'h9);
        next_cycle();
        ext_req = 1'b1; ext_we = 1'b0; ext_addr = 12'h123;
        cpu_cs = 1'b0; cpu_addr = 12'h3C3;
        exp_q.push_back(4'h9);
        @(negedge clk);
        check("rd_c1_state", 32'(dbg_state), 32'(ARB_IDLE));
        check("rd_c1_addr", 32'(ram_addr), 32'h3C3);
        next_cycle();
        @(negedge clk);
        check("rd_c2_state", 32'(dbg_state), 32'(ARB_EXT));
        check("rd_c2_addr", 32'(ram_addr), 32'h123);
        check("rd_c2_cs", 32'(ram_cs), 32'd1);
        check("rd_c2_we", 32'(ram_we), 32'd0);
        check("rd_c2_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        check("rd_c3_ack", 32'(ext_ack), 32'd1);
        ext_req = 1'b0;
        check("rd_c3_rdata", 32'(ext_rdata), 32'(exp_q.pop_front()));
        @(negedge clk);
        check("rd_c3_stall", 32'(cpu_stall), 32'd0);
        next_cycle();
        check("rd_c4_ack", 32'(ext_ack), 32'd0);

        // External write then core read, top and bottom addresses
        ext_access(1'b1, 12'hFFF, 4'h5);
        exp_q.push_back(4'h5);
        cpu_read_check("core_rd_fff", 12'hFFF);
        ext_access(1'b1, 12'h000, 4'hA);
        exp_q.push_back(4'hA);
        cpu_read_check("core_rd_000", 12'h000);

        // Starvation: core writes 12'h010 every cycle, ext write to 12'h020
        d = 4'h1;
        stalled_d = '0;
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = d;
            if (c == 1) begin
                ext_req = 1'b1; ext_we = 1'b1; ext_addr = 12'h020; ext_wdata = 4'hC;
            end
            check("sv_ack", 32'(ext_ack), 32'(c == SL + 3));
            if (ext_ack) ext_req = 1'b0;
            if (c == 7) check("sv_replay", 32'(mem[12'h010]), 32'(stalled_d));
            @(negedge clk);
            check("sv_stall", 32'(cpu_stall), 32'(c == SL + 2));
            check("sv_wait", 32'(dbg_wait_cnt), (c <= SL + 1) ? 32'(c - 1) : 32'd0);
            check("sv_addr", 32'(ram_addr), (c == SL + 2) ? 32'h020 : 32'h010);
            if (c == SL + 2) check("sv_wdata", 32'(ram_wdata), 32'hC);
            if (cpu_stall) stalled_d = d;
            else d = d + 4'h1;
        end
        cpu_cs = 1'b0; cpu_we = 1'b0;
        check("sv_ext_landed", 32'(mem[12'h020]), 32'hC);

        // Back-to-back: three reads with ext_req held, core reads in DONE slots
        for (int i = 0; i < 3; i++) begin
            bb_addr[i] = 12'h200 + 12'(i);
            bb_data[i] = 4'($urandom_range(0, 15));
            cpu_write(bb_addr[i], bb_data[i]);
        end
        idx = 0;
        for (int c = 1; c <= 9; c++) begin
            next_cycle();
            cpu_cs = (c % 3 == 0); cpu_we = 1'b0; cpu_addr = 12'h7F0;
            if (c == 1) begin
                ext_req = 1'b1; ext_we = 1'b0; ext_addr = bb_addr[0];
                exp_q.push_back(bb_data[0]);
            end
            check("bb_ack", 32'(ext_ack), 32'(c % 3 == 0));
            if (ext_ack) begin
                check("bb_rdata", 32'(ext_rdata), 32'(exp_q.pop_front()));
                idx++;
                if (idx < 3) begin
                    ext_addr = bb_addr[idx];
                    exp_q.push_back(bb_data[idx]);
                end else begin
                    ext_req = 1'b0;
                end
            end
            @(negedge clk);
            check("bb_ram_cs", 32'(ram_cs), (c % 3 == 2) ? 32'd1 : 32'(cpu_cs));
            check("bb_stall", 32'(cpu_stall), 32'd0);
        end
        cpu_cs = 1'b0;
        next_cycle();
        check("bb_ack_end", 32'(ext_ack), 32'd0);

        // Random external write / read-back round
        for (int i = 0; i < 6; i++) begin
            ra = 12'($urandom_range(0, 4095));
            d  = 4'($urandom_range(0, 15));
            ext_access(1'b1, ra, d);
            exp_q.push_back(d);
            ext_access(1'b0, ra, 4'h0);
        end

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
